instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the 5-stage MIPS pipeline, directly upstream of decode/sign_extend.
//  Holds the byte-addressed PC (+4 per fetch), drives the instruction memory address
//  and latches the fetched word into the IF/ID register. Handles stall, branch
//  redirect/flush and a HALT word; if_id_instr[15:0] feeds sign_extend.immediate.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  NOP_WORD   32'h0000_0000  bubble placed in IF/ID (sll $0,$0,0)
//  HALT_WORD  32'hFFFF_FFFF  instruction word that stops fetching
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  reset           in   1   synchronous, active-high
//  stall           in   1   hazard unit: hold PC and IF/ID
//  branch_taken    in   1   redirect request (resolved branch/jump)
//  branch_target   in   32  byte address to fetch after redirect
//  imem_addr       out  32  instruction memory address (= pc, combinational)
//  imem_data       in   32  instruction word, combinational read of imem_addr
//  if_id_instr     out  32  registered instruction to decode
//  if_id_pc_plus4  out  32  registered address of that instruction + 4
//  if_id_valid     out  1   1 = if_id_instr is a real instruction, 0 = bubble
//  immediate       out  16  if_id_instr[15:0], to sign_extend
//  halted          out  1   1 while in HALTED state
// BEHAVIOUR
//  - Reset (sync, active-high): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0,
//    if_id_valid=0, state=FETCH, halted=0. Reset overrides every other input.
//  - Priority each edge: reset > branch_taken > stall > HALT detect > normal fetch.
//  - FETCH, normal: IF/ID <= {imem_data, pc+4, valid=1}; pc <= pc+4. Latency: word
//    at address A appears on if_id_instr one edge after pc==A.
//  - branch_taken (FETCH or HALTED, stall ignored): pc <= {branch_target[31:2],2'b00};
//    IF/ID <= {NOP_WORD, 0, valid=0} (flush); state <= FETCH. The word at the old pc
//    is discarded.
//  - stall (no branch_taken): pc, IF/ID, state unchanged.
//  - HALT detect (FETCH, imem_data==HALT_WORD, no stall/redirect): pc holds,
//    IF/ID <= bubble, state <= HALTED; halted=1 from the following cycle.
//  - HALTED: pc holds, IF/ID <= bubble each cycle; only branch_taken or reset exits
//    (an older in-flight branch may skip the halt word).
//  - Arithmetic: 32-bit modulo; pc=32'hFFFF_FFFC fetch -> pc=0, pc_plus4=0.
//    pc[1:0] always 00.
//  - immediate is combinational from if_id_instr; no extra state.
// STRUCTURE
//  - Shared include pipeline_defs.vh: NOP_WORD, HALT_WORD, RESET_PC defaults, and
//    IF state encodings (S_FETCH=1'b0, S_HALTED=1'b1), reused by ID/EX stages.
//  - One sub-module: if_id_register (instr, pc_plus4, valid; load/flush/hold
//    controls), reused shape for later pipeline registers. PC, next-PC mux and FSM
//    are in instruction_fetch.
// TESTING
//  1 reset 2 cycles, imem = incrementing words -> pc=0, valid=0; then IF/ID shows
//    word@0 with pc_plus4=4, word@4 with pc_plus4=8, valid=1 each cycle.
//  2 stall high 3 cycles at pc=8 -> pc stays 8, if_id_instr/pc_plus4 frozen; resumes
//    with word@8 after release.
//  3 branch_taken=1, target=32'h0000_0042 at pc=16 -> next pc=32'h40, IF/ID bubble
//    (NOP, valid=0), then word@0x40 with pc_plus4=0x44.
//  4 branch_taken and stall together -> redirect wins, flush as in 3.
//  5 imem_data=HALT_WORD at pc=0x20 -> halted=1 next cycle, pc stays 0x20, bubbles
//    only; later branch_taken target 0x100 -> halted=0, fetch resumes at 0x100.
//  6 pc forced to 32'hFFFF_FFFC via branch -> next pc=0, if_id_pc_plus4=0; reset
//    asserted mid-stall/halt -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the IF stage: default words, state encoding and the IF/ID payload.
// The ID and EX stages reuse these definitions.
package instruction_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP       = 32'd4;

    typedef enum logic {
        S_FETCH  = 1'b0,
        S_HALTED = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    // Fetch addresses are word aligned; the low two bits of any target are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the IF stage and its environment: imem port, hazard/redirect inputs,
// and the IF/ID register outputs that feed decode.
interface instruction_fetch_if;

    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] immediate;
    logic        halted;

    modport master (
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  imem_data,
        output imem_addr,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        output immediate,
        output halted
    );

    modport slave (
        output stall,
        output branch_taken,
        output branch_target,
        output imem_data,
        input  imem_addr,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  immediate,
        input  halted
    );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register: reset and flush insert a bubble, load captures, otherwise hold.
// Later pipeline registers follow this same shape.
module if_id_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   load_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            q_q <= '{instr: NOP_WORD, pc_plus4: 32'd0, valid: 1'b0};
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: byte-addressed PC, next-PC selection, FETCH/HALTED control and the IF/ID register.
// Edge priority is reset > redirect > stall > halt word > normal fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_WORD  = DEF_NOP_WORD,
    parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    if_state_e   state_q;
    logic        halted_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic        halt_seen;
    logic        ifid_load;
    logic        ifid_flush;
    if_id_t      ifid_d;
    if_id_t      ifid_q;

    assign pc_plus4  = pc_q + PC_STEP;
    assign halt_seen = (state_q == S_FETCH) && (bus.imem_data == HALT_WORD);

    always_comb begin
        pc_d       = pc_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        if (bus.branch_taken) begin
            pc_d       = align_word(bus.branch_target);
            ifid_flush = 1'b1;
        end else if (!bus.stall) begin
            if ((state_q == S_HALTED) || halt_seen) begin
                ifid_flush = 1'b1;
            end else begin
                pc_d      = pc_plus4;
                ifid_load = 1'b1;
            end
        end
    end

    // halted_q mirrors the state so the output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= align_word(RESET_PC);
            state_q  <= S_FETCH;
            halted_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (bus.branch_taken) begin
                state_q  <= S_FETCH;
                halted_q <= 1'b0;
            end else if (!bus.stall && halt_seen) begin
                state_q  <= S_HALTED;
                halted_q <= 1'b1;
            end
        end
    end

    assign ifid_d = '{instr: bus.imem_data, pc_plus4: pc_plus4, valid: 1'b1};

    if_id_register #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .clk_i   (clk),
        .rst_i   (reset),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .d_i     (ifid_d),
        .q_o     (ifid_q)
    );

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_instr    = ifid_q.instr;
    assign bus.if_id_pc_plus4 = ifid_q.pc_plus4;
    assign bus.if_id_valid    = ifid_q.valid;
    assign bus.immediate      = ifid_q.instr[15:0];
    assign bus.halted         = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios then random stall/redirect/halt
// traffic, with expectations from a cycle-level reference model of the fetch rules.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic clk;
    logic reset;
    logic [31:0] halt_addr;

    instruction_fetch_if bus ();

    instruction_fetch u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory: incrementing words, with one programmable location holding HALT.
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
        if (a == h) return HALT;
        return (a >> 2) + 32'h1000_0000;
    endfunction

    assign bus.imem_data = mem_word(bus.imem_addr, halt_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] p4;
        logic        v;
        logic        h;
    } exp_t;

    exp_t exp_q[$];

    int n_total  = 0;
    int n_passed = 0;
    bit started  = 1'b0;

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_v, m_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s @%0t actual=%h expected=%h", name, $time, act, exp);
        else
            n_passed++;
    endtask

    // One clock: drive inputs, advance the model, queue what the DUT must show after the edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        logic [31:0] w;
        exp_t e;
        reset             = r;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = t;
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_p4 = 32'h0; m_v = 1'b0; m_h = 1'b0;
        end else if (b) begin
            m_pc = t & ~32'h3; m_instr = NOP; m_p4 = 32'h0; m_v = 1'b0; m_h = 1'b0;
        end else if (s) begin
            // everything holds
        end else if (m_h) begin
            m_instr = NOP; m_p4 = 32'h0; m_v = 1'b0;
        end else begin
            w = mem_word(m_pc, halt_addr);
            if (w == HALT) begin
                m_h = 1'b1; m_instr = NOP; m_p4 = 32'h0; m_v = 1'b0;
            end else begin
                m_instr = w; m_p4 = m_pc + 32'd4; m_v = 1'b1; m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.p4 = m_p4; e.v = m_v; e.h = m_h;
        exp_q.push_back(e);
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Monitor: the DUT presents a new IF/ID value every edge; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",        bus.imem_addr,                 e.pc);
                chk("instr",     bus.if_id_instr,               e.instr);
                chk("pc_plus4",  bus.if_id_pc_plus4,            e.p4);
                chk("valid",     {31'd0, bus.if_id_valid},      {31'd0, e.v});
                chk("halted",    {31'd0, bus.halted},           {31'd0, e.h});
                chk("immediate", {16'd0, bus.immediate},        {16'd0, e.instr[15:0]});
            end else if (started) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        halt_addr         = 32'h0000_0001;
        reset             = 1'b1;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;

        // Reset, then sequential fetch from 0.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(2);
        // Stall three cycles at pc=8, then resume.
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        run(2);
        // Redirect at pc=16 to unaligned 0x42.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0042);
        run(2);
        // Redirect together with stall.
        step(1'b0, 1'b1, 1'b1, 32'h0000_0080);
        run(1);
        // Halt word at 0x20, sit in HALTED (with a stall), then exit by redirect.
        halt_addr = 32'h0000_0020;
        step(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        run(3);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        run(1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        run(2);
        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        run(2);
        // Reset during a stall, and during HALTED.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        run(1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        run(2);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run(1);

        // Random traffic in a small window so halt words and redirects collide often.
        for (int i = 0; i < 400; i++) begin
            logic r, s, b;
            logic [31:0] t;
            if ($urandom_range(0, 19) == 0) halt_addr = $urandom_range(0, 63) << 2;
            r = ($urandom_range(0, 99) == 0);
            s = ($urandom_range(0, 4) == 0);
            b = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) t = $urandom;
            else                           t = $urandom_range(0, 255);
            step(r, s, b, t);
        end

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
